// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes the ALU control code, selects operand B and
// forwards EX/MEM or MEM/WB results onto the latched source operands.
module id_ex_stage #(
    parameter int          XLEN    = 32,
    parameter logic [5:0]  ILLEGAL = 6'd63
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic [4:0]      rs1_idx,
    input  logic [4:0]      rs2_idx,
    input  logic [4:0]      rd_idx,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    input  logic            stall,
    input  logic            flush,
    input  logic            mem_wr_en,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_wr_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] srca,
    output logic [XLEN-1:0] srcb,
    output logic [5:0]      aluCtrl,
    output logic            ex_valid,
    output logic [4:0]      ex_rd,
    output logic            ex_wr_en,
    output logic            ex_branch,
    output logic            ex_illegal
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;

    localparam logic [5:0] ALU_ADD  = 6'd0;
    localparam logic [5:0] ALU_SUB  = 6'd1;
    localparam logic [5:0] ALU_XOR  = 6'd2;
    localparam logic [5:0] ALU_SLL  = 6'd3;
    localparam logic [5:0] ALU_SRL  = 6'd4;
    localparam logic [5:0] ALU_SRA  = 6'd5;
    localparam logic [5:0] ALU_AND  = 6'd6;
    localparam logic [5:0] ALU_OR   = 6'd7;
    localparam logic [5:0] ALU_SLT  = 6'd8;
    localparam logic [5:0] ALU_BEQ  = 6'd9;
    localparam logic [5:0] ALU_BNE  = 6'd10;
    localparam logic [5:0] ALU_BLT  = 6'd11;
    localparam logic [5:0] ALU_BGE  = 6'd12;
    localparam logic [5:0] ALU_SLTU = 6'd13;
    localparam logic [5:0] ALU_BLTU = 6'd14;
    localparam logic [5:0] ALU_BGEU = 6'd15;

    logic [5:0]      ctrl_next;
    logic            wr_en_next;
    logic            branch_next;
    logic            illegal_next;
    logic            imm_sel_next;

    logic            valid_reg;
    logic [5:0]      ctrl_reg;
    logic            wr_en_reg;
    logic            branch_reg;
    logic            illegal_reg;
    logic            imm_sel_reg;
    logic [4:0]      rd_reg;
    logic [XLEN-1:0] imm_reg;
    logic [4:0]      rs_idx_reg [2];
    logic [XLEN-1:0] rs_val_reg [2];
    logic [XLEN-1:0] fwd_val    [2];

    logic capture;
    logic update;

    always_comb begin
        ctrl_next    = ALU_ADD;
        wr_en_next   = 1'b0;
        branch_next  = 1'b0;
        illegal_next = 1'b0;
        imm_sel_next = 1'b0;
        case (opcode)
            OP_R, OP_I: begin
                wr_en_next   = 1'b1;
                imm_sel_next = (opcode == OP_I);
                case (funct3)
                    3'b000: ctrl_next = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001: ctrl_next = ALU_SLL;
                    3'b010: ctrl_next = ALU_SLT;
                    3'b011: ctrl_next = ALU_SLTU;
                    3'b100: ctrl_next = ALU_XOR;
                    3'b101: ctrl_next = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110: ctrl_next = ALU_OR;
                    default: ctrl_next = ALU_AND;
                endcase
            end
            OP_B: begin
                branch_next = 1'b1;
                case (funct3)
                    3'b000: ctrl_next = ALU_BEQ;
                    3'b001: ctrl_next = ALU_BNE;
                    3'b100: ctrl_next = ALU_BLT;
                    3'b101: ctrl_next = ALU_BGE;
                    3'b110: ctrl_next = ALU_BLTU;
                    3'b111: ctrl_next = ALU_BGEU;
                    default: begin
                        // an undecodable branch is treated as illegal, not as a branch
                        ctrl_next    = ILLEGAL;
                        branch_next  = 1'b0;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            OP_LD: begin
                wr_en_next   = 1'b1;
                imm_sel_next = 1'b1;
            end
            OP_ST: imm_sel_next = 1'b1;
            default: begin
                ctrl_next    = ILLEGAL;
                illegal_next = 1'b1;
            end
        endcase
    end

    // flush overrides stall; an idle ID or a flush loads an all-zero bubble
    assign capture = in_valid & ~stall & ~flush;
    assign update  = flush | ~stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg     <= 1'b0;
            ctrl_reg      <= '0;
            wr_en_reg     <= 1'b0;
            branch_reg    <= 1'b0;
            illegal_reg   <= 1'b0;
            imm_sel_reg   <= 1'b0;
            rd_reg        <= '0;
            imm_reg       <= '0;
            rs_idx_reg[0] <= '0;
            rs_idx_reg[1] <= '0;
            rs_val_reg[0] <= '0;
            rs_val_reg[1] <= '0;
        end else if (update) begin
            valid_reg     <= capture;
            ctrl_reg      <= capture ? ctrl_next    : '0;
            wr_en_reg     <= capture & wr_en_next;
            branch_reg    <= capture & branch_next;
            illegal_reg   <= capture & illegal_next;
            imm_sel_reg   <= capture & imm_sel_next;
            rd_reg        <= capture ? rd_idx  : '0;
            imm_reg       <= capture ? imm     : '0;
            rs_idx_reg[0] <= capture ? rs1_idx : '0;
            rs_idx_reg[1] <= capture ? rs2_idx : '0;
            rs_val_reg[0] <= capture ? rs1_val : '0;
            rs_val_reg[1] <= capture ? rs2_val : '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic nonzero;
            logic mem_hit;
            logic wb_hit;
            assign nonzero = (rs_idx_reg[gi] != 5'd0);
            assign mem_hit = nonzero & mem_wr_en & (mem_rd == rs_idx_reg[gi]);
            assign wb_hit  = nonzero & wb_wr_en  & (wb_rd  == rs_idx_reg[gi]);
            assign fwd_val[gi] = mem_hit ? mem_result :
                                 wb_hit  ? wb_result  : rs_val_reg[gi];
        end
    endgenerate

    assign srca       = fwd_val[0];
    assign srcb       = imm_sel_reg ? imm_reg : fwd_val[1];
    assign aluCtrl    = ctrl_reg;
    assign ex_valid   = valid_reg;
    assign ex_rd      = rd_reg;
    assign ex_wr_en   = wr_en_reg;
    assign ex_branch  = branch_reg;
    assign ex_illegal = illegal_reg;
    assign in_ready   = ~stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a stage-level model is checked every cycle,
// and literal expectations pin the model on the scenarios of interest.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rs1_idx, rs2_idx, rd_idx;
    logic [31:0] rs1_val, rs2_val, imm;
    logic        stall, flush;
    logic        mem_wr_en, wb_wr_en;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_result, wb_result;
    logic [31:0] srca, srcb;
    logic [5:0]  aluCtrl;
    logic        ex_valid, ex_wr_en, ex_branch, ex_illegal;
    logic [4:0]  ex_rd;

    int total = 0;
    int bad   = 0;
    bit run   = 1'b0;

    id_ex_stage #(.XLEN(32), .ILLEGAL(6'd63)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rd_idx(rd_idx),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
        .stall(stall), .flush(flush),
        .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_result(wb_result),
        .srca(srca), .srcb(srcb), .aluCtrl(aluCtrl), .ex_valid(ex_valid),
        .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_branch(ex_branch), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    // ALU codes by funct3 for ALU ops and for branches (63 = undecodable)
    localparam logic [5:0] ALU_TAB [8] = '{6'd0, 6'd3, 6'd8, 6'd13, 6'd2, 6'd4, 6'd7, 6'd6};
    localparam logic [5:0] BR_TAB  [8] = '{6'd9, 6'd10, 6'd63, 6'd63, 6'd11, 6'd12, 6'd14, 6'd15};

    typedef struct packed {
        logic [5:0] code;
        logic       wr;
        logic       br;
        logic       ill;
        logic       isel;
    } dec_t;

    typedef struct packed {
        logic        valid;
        dec_t        d;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
    } mstate_t;

    mstate_t m = '0;

    function automatic dec_t model_decode(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        dec_t d;
        d = '0;
        if (op == 7'b0110011 || op == 7'b0010011) begin
            d.code = ALU_TAB[f3];
            if (f3 == 3'd5 && f7) d.code = 6'd5;
            if (f3 == 3'd0 && f7 && op == 7'b0110011) d.code = 6'd1;
            d.wr   = 1'b1;
            d.isel = (op == 7'b0010011);
        end else if (op == 7'b1100011) begin
            d.code = BR_TAB[f3];
            d.ill  = (d.code == 6'd63);
            d.br   = !d.ill;
        end else if (op == 7'b0000011) begin
            d.wr   = 1'b1;
            d.isel = 1'b1;
        end else if (op == 7'b0100011) begin
            d.isel = 1'b1;
        end else begin
            d.code = 6'd63;
            d.ill  = 1'b1;
        end
        return d;
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] v);
        if (idx == 5'd0) return v;
        if (mem_wr_en && mem_rd == idx) return mem_result;
        if (wb_wr_en && wb_rd == idx) return wb_result;
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '0;
        end else if (flush || (!stall && !in_valid)) begin
            m <= '0;
        end else if (!stall) begin
            m <= '{valid: 1'b1, d: model_decode(opcode, funct3, funct7b5), rd: rd_idx,
                   rs1: rs1_idx, rs2: rs2_idx, v1: rs1_val, v2: rs2_val, imm: imm};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("model srca",       srca,       fwd(m.rs1, m.v1));
            chk("model srcb",       srcb,       m.d.isel ? m.imm : fwd(m.rs2, m.v2));
            chk("model aluCtrl",    {26'd0, aluCtrl}, {26'd0, m.d.code});
            chk("model ex_valid",   {31'd0, ex_valid},   {31'd0, m.valid});
            chk("model ex_rd",      {27'd0, ex_rd},      {27'd0, m.rd});
            chk("model ex_wr_en",   {31'd0, ex_wr_en},   {31'd0, m.d.wr});
            chk("model ex_branch",  {31'd0, ex_branch},  {31'd0, m.d.br});
            chk("model ex_illegal", {31'd0, ex_illegal}, {31'd0, m.d.ill});
            chk("model in_ready",   {31'd0, in_ready},   {31'd0, !stall});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] im);
        in_valid = 1'b1;
        opcode = op; funct3 = f3; funct7b5 = f7;
        rs1_idx = r1; rs2_idx = r2; rd_idx = rd;
        rs1_val = v1; rs2_val = v2; imm = im;
    endtask

    task automatic fwd_set(input logic me, input logic [4:0] mr, input logic [31:0] mv,
                           input logic we, input logic [4:0] wr, input logic [31:0] wv);
        mem_wr_en = me; mem_rd = mr; mem_result = mv;
        wb_wr_en = we; wb_rd = wr; wb_result = wv;
    endtask

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        int         code;
        bit         wr;
        bit         br;
        bit         ill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                input int code, input bit wr, input bit br, input bit ill);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.code = code; v.wr = wr; v.br = br; v.ill = ill;
        return v;
    endfunction

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        in_valid = 1'b0;
        fwd_set(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        run = 1'b1;

        // reset state
        step(); step();
        chk("reset srca", srca, 32'd0);
        chk("reset srcb", srcb, 32'd0);
        chk("reset aluCtrl", {26'd0, aluCtrl}, 32'd0);
        chk("reset ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        step();

        // R add
        drive(7'b0110011, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd21, 32'd10, 32'd0);
        step();
        chk("radd aluCtrl", {26'd0, aluCtrl}, 32'd0);
        chk("radd srca", srca, 32'd21);
        chk("radd srcb", srcb, 32'd10);
        chk("radd ex_wr_en", {31'd0, ex_wr_en}, 32'd1);

        // srai: immediate never overridden by forwarding
        drive(7'b0010011, 3'd5, 1'b1, 5'd7, 5'd6, 5'd8, 32'd100, 32'd200, 32'd4);
        fwd_set(1'b1, 5'd6, 32'd77, 1'b0, 5'd0, 32'd0);
        step();
        chk("srai aluCtrl", {26'd0, aluCtrl}, 32'd5);
        chk("srai srcb", srcb, 32'd4);

        // forwarding priority
        drive(7'b0110011, 3'd0, 1'b0, 5'd5, 5'd0, 5'd4, 32'd1, 32'd0, 32'd0);
        fwd_set(1'b1, 5'd5, 32'd7, 1'b1, 5'd5, 32'd9);
        step();
        chk("fwd mem wins", srca, 32'd7);
        stall = 1'b1;
        mem_wr_en = 1'b0;
        #1;
        chk("fwd wb", srca, 32'd9);
        step();
        stall = 1'b0;

        // x0 never forwards
        drive(7'b0110011, 3'd0, 1'b0, 5'd0, 5'd0, 5'd2, 32'd55, 32'd0, 32'd0);
        fwd_set(1'b1, 5'd0, 32'd99, 1'b1, 5'd0, 32'd98);
        step();
        chk("x0 srca", srca, 32'd55);
        fwd_set(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // stall for 3 cycles, then flush+stall
        drive(7'b0110011, 3'd0, 1'b1, 5'd2, 5'd3, 5'd9, 32'd50, 32'd8, 32'd0);
        step();
        stall = 1'b1;
        drive(7'b0110011, 3'd4, 1'b0, 5'd11, 5'd12, 5'd13, 32'd1, 32'd2, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall aluCtrl", {26'd0, aluCtrl}, 32'd1);
            chk("stall srca", srca, 32'd50);
            chk("stall ex_rd", {27'd0, ex_rd}, 32'd9);
            chk("stall in_ready", {31'd0, in_ready}, 32'd0);
        end
        flush = 1'b1;
        step();
        chk("flush ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush aluCtrl", {26'd0, aluCtrl}, 32'd0);
        chk("flush ex_wr_en", {31'd0, ex_wr_en}, 32'd0);
        flush = 1'b0; stall = 1'b0;

        // branches
        drive(7'b1100011, 3'd2, 1'b0, 5'd1, 5'd2, 5'd0, 32'd3, 32'd4, 32'd0);
        step();
        chk("br010 aluCtrl", {26'd0, aluCtrl}, 32'd63);
        chk("br010 ex_illegal", {31'd0, ex_illegal}, 32'd1);
        drive(7'b1100011, 3'd7, 1'b0, 5'd1, 5'd2, 5'd0, 32'd3, 32'd4, 32'd0);
        step();
        chk("bgeu aluCtrl", {26'd0, aluCtrl}, 32'd15);
        chk("bgeu ex_branch", {31'd0, ex_branch}, 32'd1);
        chk("bgeu ex_wr_en", {31'd0, ex_wr_en}, 32'd0);

        // idle ID -> bubble
        in_valid = 1'b0;
        step();
        chk("bubble ex_valid", {31'd0, ex_valid}, 32'd0);

        // decode table with random operands and forwarding traffic
        vecs.push_back(mk(7'b0110011, 3'd0, 1'b0,  0, 1, 0, 0));
        vecs.push_back(mk(7'b0110011, 3'd0, 1'b1,  1, 1, 0, 0));
        vecs.push_back(mk(7'b0110011, 3'd1, 1'b0,  3, 1, 0, 0));
        vecs.push_back(mk(7'b0110011, 3'd2, 1'b0,  8, 1, 0, 0));
        vecs.push_back(mk(7'b0110011, 3'd3, 1'b0, 13, 1, 0, 0));
        vecs.push_back(mk(7'b0110011, 3'd4, 1'b0,  2, 1, 0, 0));
        vecs.push_back(mk(7'b0110011, 3'd5, 1'b0,  4, 1, 0, 0));
        vecs.push_back(mk(7'b0110011, 3'd5, 1'b1,  5, 1, 0, 0));
        vecs.push_back(mk(7'b0110011, 3'd6, 1'b0,  7, 1, 0, 0));
        vecs.push_back(mk(7'b0110011, 3'd7, 1'b0,  6, 1, 0, 0));
        vecs.push_back(mk(7'b0010011, 3'd0, 1'b1,  0, 1, 0, 0));
        vecs.push_back(mk(7'b0010011, 3'd5, 1'b0,  4, 1, 0, 0));
        vecs.push_back(mk(7'b0010011, 3'd2, 1'b0,  8, 1, 0, 0));
        vecs.push_back(mk(7'b1100011, 3'd0, 1'b0,  9, 0, 1, 0));
        vecs.push_back(mk(7'b1100011, 3'd1, 1'b0, 10, 0, 1, 0));
        vecs.push_back(mk(7'b1100011, 3'd4, 1'b0, 11, 0, 1, 0));
        vecs.push_back(mk(7'b1100011, 3'd5, 1'b0, 12, 0, 1, 0));
        vecs.push_back(mk(7'b1100011, 3'd6, 1'b0, 14, 0, 1, 0));
        vecs.push_back(mk(7'b1100011, 3'd3, 1'b0, 63, 0, 0, 1));
        vecs.push_back(mk(7'b0000011, 3'd2, 1'b0,  0, 1, 0, 0));
        vecs.push_back(mk(7'b0100011, 3'd2, 1'b0,  0, 0, 0, 0));
        vecs.push_back(mk(7'b1101111, 3'd0, 1'b0, 63, 0, 0, 1));
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].f3, vecs[i].f7,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  $urandom, $urandom, $urandom);
            fwd_set(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            step();
            $display("txn %0d op=%b f3=%0d f7b5=%0d aluCtrl=%0d wr=%0d br=%0d ill=%0d",
                     i, vecs[i].op, vecs[i].f3, vecs[i].f7, aluCtrl, ex_wr_en, ex_branch, ex_illegal);
            chk("tab aluCtrl",    {26'd0, aluCtrl},    vecs[i].code);
            chk("tab ex_wr_en",   {31'd0, ex_wr_en},   {31'd0, vecs[i].wr});
            chk("tab ex_branch",  {31'd0, ex_branch},  {31'd0, vecs[i].br});
            chk("tab ex_illegal", {31'd0, ex_illegal}, {31'd0, vecs[i].ill});
        end

        // asynchronous reset mid-operation
        fwd_set(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        drive(7'b0110011, 3'd7, 1'b0, 5'd3, 5'd4, 5'd5, 32'd123, 32'd456, 32'd0);
        step();
        chk("pre-reset ex_valid", {31'd0, ex_valid}, 32'd1);
        stall = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async srca", srca, 32'd0);
        chk("async srcb", srcb, 32'd0);
        chk("async aluCtrl", {26'd0, aluCtrl}, 32'd0);
        chk("async ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("async ex_rd", {27'd0, ex_rd}, 32'd0);
        chk("async in_ready", {31'd0, in_ready}, 32'd0);
        step();
        stall = 1'b0;
        rst_n = 1'b1;
        step();

        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
